// File: rtl/grey_stat_pkg.sv
// Shared constants and helpers for the grey-statistics AOI selector blocks.
package grey_stat_pkg;

    localparam int CHANNEL_NUM_MAX = 8;
    localparam int WIN_NUM_MAX     = 8;

    localparam logic [2:0] TEST_IMG_REAL = 3'b000;

    // LSB position of field idx inside a vector of equal-width packed fields
    function automatic int fld_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/grey_aoi_win_cmp.sv
// One statistic window: frame-shadowed geometry, end adders and per-lane range compares.
module grey_aoi_win_cmp
    import grey_stat_pkg::*;
#(
    parameter int GW = 12,
    parameter int CH = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          shadow_ld_i,
    input  logic          act_gate_i,
    input  logic          pix_gate_i,
    input  logic          en_i,
    input  logic [GW-1:0] x_start_i,
    input  logic [GW-1:0] width_i,
    input  logic [GW-1:0] y_start_i,
    input  logic [GW-1:0] height_i,
    input  logic [GW-1:0] grp_cnt_i,
    input  logic [GW-1:0] line_cnt_i,
    output logic          win_act_o,
    output logic [GW-1:0] sh_width_o,
    output logic [GW-1:0] sh_height_o,
    output logic [CH-1:0] lane_vld_o
);

    localparam int XW = GW + 3;

    logic          sh_en_q;
    logic [GW-1:0] sh_xs_q, sh_w_q, sh_ys_q, sh_h_q;
    logic          win_act_q;
    logic [GW:0]   x_end, y_end;
    logic          y_hit;
    logic [XW-1:0] x_lane;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sh_en_q   <= 1'b0;
            sh_xs_q   <= '0;
            sh_w_q    <= '0;
            sh_ys_q   <= '0;
            sh_h_q    <= '0;
            win_act_q <= 1'b0;
        end else begin
            if (shadow_ld_i) begin
                sh_en_q <= en_i;
                sh_xs_q <= x_start_i;
                sh_w_q  <= width_i;
                sh_ys_q <= y_start_i;
                sh_h_q  <= height_i;
            end
            win_act_q <= act_gate_i & sh_en_q & (|sh_w_q) & (|sh_h_q);
        end
    end

    // One extra bit so start+size never wraps back into the visible range
    assign x_end = {1'b0, sh_xs_q} + {1'b0, sh_w_q};
    assign y_end = {1'b0, sh_ys_q} + {1'b0, sh_h_q};

    always_comb begin
        y_hit  = ({1'b0, line_cnt_i} >= {1'b0, sh_ys_q}) && ({1'b0, line_cnt_i} < y_end);
        x_lane = '0;
        lane_vld_o = '0;
        for (int k = 0; k < CH; k++) begin
            x_lane = XW'(grp_cnt_i) * XW'(CH) + XW'(k);
            lane_vld_o[k] = pix_gate_i & win_act_q & y_hit &
                            (x_lane >= XW'(sh_xs_q)) & (x_lane < XW'(x_end));
        end
    end

    assign win_act_o   = win_act_q;
    assign sh_width_o  = sh_w_q;
    assign sh_height_o = sh_h_q;

endmodule

// File: rtl/grey_aoi_sel_mw.sv
// Multi-window, multi-lane AOI selector: counters, edge detect, interrupt enable and 2-stage output pipe.
module grey_aoi_sel_mw
    import grey_stat_pkg::*;
#(
    parameter int SENSOR_DAT_WIDTH  = 10,
    parameter int GREY_OFFSET_WIDTH = 12,
    parameter int CHANNEL_NUM       = 2,
    parameter int WIN_NUM           = 4
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   i_fval,
    input  logic                                   i_lval,
    input  logic [CHANNEL_NUM*SENSOR_DAT_WIDTH-1:0] iv_pix_data,
    input  logic                                   i_interrupt_en,
    input  logic [2:0]                             iv_test_image_sel,
    input  logic [WIN_NUM-1:0]                     iv_win_en,
    input  logic [WIN_NUM*GREY_OFFSET_WIDTH-1:0]   iv_grey_offset_x_start,
    input  logic [WIN_NUM*GREY_OFFSET_WIDTH-1:0]   iv_grey_offset_width,
    input  logic [WIN_NUM*GREY_OFFSET_WIDTH-1:0]   iv_grey_offset_y_start,
    input  logic [WIN_NUM*GREY_OFFSET_WIDTH-1:0]   iv_grey_offset_height,
    input  logic                                   i_interrupt_pin,
    output logic [WIN_NUM*GREY_OFFSET_WIDTH-1:0]   ov_grey_offset_width,
    output logic [WIN_NUM*GREY_OFFSET_WIDTH-1:0]   ov_grey_offset_height,
    output logic                                   o_interrupt_en,
    output logic                                   o_fval,
    output logic                                   o_lval,
    output logic [WIN_NUM*CHANNEL_NUM-1:0]         ov_win_valid,
    output logic [CHANNEL_NUM*SENSOR_DAT_WIDTH-1:0] ov_pix_data
);

    localparam int GW = GREY_OFFSET_WIDTH;
    localparam int CH = CHANNEL_NUM;
    localparam int DW = CHANNEL_NUM * SENSOR_DAT_WIDTH;

    logic          fval_d_q, lval_d_q, pin_d_q, arm_q;
    logic          fval_rise, fval_fall, lval_fall, pin_rise;
    logic          int_en_q, int_en_d;
    logic          inten_q, inten_d;
    logic [GW-1:0] line_cnt_q, line_cnt_d;
    logic [GW-1:0] grp_cnt_q, grp_cnt_d;
    logic          act_gate, pix_gate;

    logic [WIN_NUM-1:0]          win_act;
    logic [WIN_NUM-1:0][CH-1:0]  lane_vld;
    logic [WIN_NUM-1:0][GW-1:0]  sh_w, sh_h;
    logic [WIN_NUM-1:0][GW-1:0]  rb_w_q, rb_h_q;
    logic [WIN_NUM-1:0][CH-1:0]  vld_s1_q, vld_s2_q;
    logic                        lval_o_q;
    logic                        fval_s1_q, fval_s2_q;
    logic [DW-1:0]               pix_s1_q, pix_s2_q;

    // arm_q suppresses a false frame start when reset is released mid-frame
    assign fval_rise = i_fval & ~fval_d_q & arm_q;
    assign fval_fall = ~i_fval & fval_d_q;
    assign lval_fall = ~i_lval & lval_d_q;
    assign pin_rise  = i_interrupt_pin & ~pin_d_q;
    assign act_gate  = int_en_q & (iv_test_image_sel == TEST_IMG_REAL);
    assign pix_gate  = i_fval & i_lval;

    always_comb begin
        int_en_d = int_en_q;
        if (!i_interrupt_en)
            int_en_d = 1'b0;
        else if (fval_rise)
            int_en_d = 1'b1;

        line_cnt_d = line_cnt_q;
        if (!i_fval)
            line_cnt_d = '0;
        else if (lval_fall)
            line_cnt_d = line_cnt_q + 1'b1;

        grp_cnt_d = (i_fval & i_lval) ? grp_cnt_q + 1'b1 : '0;

        inten_d = inten_q;
        if (win_act == '0)
            inten_d = 1'b0;
        else if (fval_fall)
            inten_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fval_d_q   <= 1'b0;
            lval_d_q   <= 1'b0;
            pin_d_q    <= 1'b0;
            arm_q      <= 1'b0;
            int_en_q   <= 1'b0;
            inten_q    <= 1'b0;
            line_cnt_q <= '0;
            grp_cnt_q  <= '0;
            rb_w_q     <= '0;
            rb_h_q     <= '0;
            vld_s1_q   <= '0;
            vld_s2_q   <= '0;
            lval_o_q   <= 1'b0;
            fval_s1_q  <= 1'b0;
            fval_s2_q  <= 1'b0;
            pix_s1_q   <= '0;
            pix_s2_q   <= '0;
        end else begin
            fval_d_q   <= i_fval;
            lval_d_q   <= i_lval;
            pin_d_q    <= i_interrupt_pin;
            arm_q      <= arm_q | ~i_fval;
            int_en_q   <= int_en_d;
            inten_q    <= inten_d;
            line_cnt_q <= line_cnt_d;
            grp_cnt_q  <= grp_cnt_d;
            // shadows update on the same edge, so a coincident frame start latches old values
            if (pin_rise) begin
                rb_w_q <= sh_w;
                rb_h_q <= sh_h;
            end
            vld_s1_q  <= lane_vld;
            vld_s2_q  <= vld_s1_q;
            lval_o_q  <= |vld_s1_q;
            fval_s1_q <= i_fval;
            fval_s2_q <= fval_s1_q;
            pix_s1_q  <= iv_pix_data;
            pix_s2_q  <= pix_s1_q;
        end
    end

    for (genvar w = 0; w < WIN_NUM; w++) begin : g_win
        grey_aoi_win_cmp #(
            .GW (GW),
            .CH (CH)
        ) u_win (
            .clk         (clk),
            .reset_n     (reset_n),
            .shadow_ld_i (fval_rise),
            .act_gate_i  (act_gate),
            .pix_gate_i  (pix_gate),
            .en_i        (iv_win_en[w]),
            .x_start_i   (iv_grey_offset_x_start[fld_lsb(w, GW) +: GW]),
            .width_i     (iv_grey_offset_width[fld_lsb(w, GW) +: GW]),
            .y_start_i   (iv_grey_offset_y_start[fld_lsb(w, GW) +: GW]),
            .height_i    (iv_grey_offset_height[fld_lsb(w, GW) +: GW]),
            .grp_cnt_i   (grp_cnt_q),
            .line_cnt_i  (line_cnt_q),
            .win_act_o   (win_act[w]),
            .sh_width_o  (sh_w[w]),
            .sh_height_o (sh_h[w]),
            .lane_vld_o  (lane_vld[w])
        );
    end

    assign ov_grey_offset_width  = rb_w_q;
    assign ov_grey_offset_height = rb_h_q;
    assign o_interrupt_en        = inten_q;
    assign o_fval                = fval_s2_q;
    assign o_lval                = lval_o_q;
    assign ov_win_valid          = vld_s2_q;
    assign ov_pix_data           = pix_s2_q;

endmodule
